// File: rtl/fd_inst_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {PC, Instr, AdEL} with
// show-ahead head presentation, flush on redirect and fetch back-pressure.
module fd_inst_queue #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] PC_LO = 32'h0000_3000,
    parameter logic [31:0] PC_HI = 32'h0000_6FFC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              F_Instr,
    input  logic [31:0]              F_PC,
    input  logic                     F_valid,
    output logic                     F_en,
    input  logic                     flush,
    input  logic                     D_ready,
    output logic                     D_valid,
    output logic [31:0]              D_Instr,
    output logic [31:0]              D_PC,
    output logic                     D_excAdEL,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][31:0] pc_mem;
    logic [DEPTH-1:0][31:0] instr_mem;
    logic [DEPTH-1:0]       adel_mem;
    logic [AW-1:0]          rptr;
    logic [AW-1:0]          wptr;

    logic        enq;
    logic        deq;
    logic        in_adel;
    logic [31:0] in_instr;

    // Misaligned or out-of-window fetches are stored as a bubble carrying the error flag.
    always_comb begin
        in_adel  = (F_PC[1:0] != 2'b00) || (F_PC < PC_LO) || (F_PC > PC_HI);
        in_instr = in_adel ? '0 : F_Instr;
    end

    always_comb begin
        F_en    = (count != FULL);
        D_valid = (count != '0);
        enq     = F_valid && F_en && !flush;
        deq     = D_valid && D_ready && !flush;
    end

    always_comb begin
        D_Instr   = '0;
        D_PC      = '0;
        D_excAdEL = 1'b0;
        if (D_valid) begin
            D_Instr   = instr_mem[rptr];
            D_PC      = pc_mem[rptr];
            D_excAdEL = adel_mem[rptr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_mem    <= '0;
            instr_mem <= '0;
            adel_mem  <= '0;
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                pc_mem[wptr]    <= F_PC;
                instr_mem[wptr] <= in_instr;
                adel_mem[wptr]  <= in_adel;
                wptr            <= wptr + AW'(1);
            end
            if (deq) begin
                rptr <= rptr + AW'(1);
            end
            // Write side is already gated by F_en, so count can never pass DEPTH.
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fd_inst_queue.sv
// Self-checking bench for fd_inst_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fd_inst_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] F_Instr;
    logic [31:0] F_PC;
    logic        F_valid;
    logic        F_en;
    logic        flush;
    logic        D_ready;
    logic        D_valid;
    logic [31:0] D_Instr;
    logic [31:0] D_PC;
    logic        D_excAdEL;
    logic [2:0]  count;

    int checks;
    int failures;

    fd_inst_queue #(
        .DEPTH (DEPTH),
        .PC_LO (32'h0000_3000),
        .PC_HI (32'h0000_6FFC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .F_Instr   (F_Instr),
        .F_PC      (F_PC),
        .F_valid   (F_valid),
        .F_en      (F_en),
        .flush     (flush),
        .D_ready   (D_ready),
        .D_valid   (D_valid),
        .D_Instr   (D_Instr),
        .D_PC      (D_PC),
        .D_excAdEL (D_excAdEL),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        dr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_adel;
        int unsigned e_count;
        logic        e_fen;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ent_t;

    vec_t vecs[8];
    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                          input logic dr, input logic fl);
        F_valid = fv;
        F_PC    = pc;
        F_Instr = instr;
        D_ready = dr;
        flush   = fl;
    endtask

    // Reset pulse placed between clock edges, released before the next edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", 32'(D_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_fen", 32'(F_en), 32'd1);
        chk("rst_pc", D_PC, 32'd0);
        chk("rst_instr", D_Instr, 32'd0);
        chk("rst_adel", 32'(D_excAdEL), 32'd0);
        #1 reset = 1'b0;
        q.delete();
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] instr);
        ent_t e;
        e.pc    = pc;
        e.adel  = (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
        e.instr = e.adel ? 32'h0 : instr;
        return e;
    endfunction

    task automatic model_edge();
        int unsigned n = q.size();
        if (flush) begin
            q.delete();
        end else begin
            if (D_ready && n != 0) void'(q.pop_front());
            if (F_valid && n != DEPTH) q.push_back(mk(F_PC, F_Instr));
        end
    endtask

    task automatic model_check(input int cyc);
        ent_t h = '0;
        if (q.size() != 0) h = q[0];
        chk($sformatf("rnd%0d_valid", cyc), 32'(D_valid), 32'(q.size() != 0));
        chk($sformatf("rnd%0d_count", cyc), 32'(count), 32'(q.size()));
        chk($sformatf("rnd%0d_fen", cyc), 32'(F_en), 32'(q.size() != DEPTH));
        chk($sformatf("rnd%0d_pc", cyc), D_PC, h.pc);
        chk($sformatf("rnd%0d_instr", cyc), D_Instr, h.instr);
        chk($sformatf("rnd%0d_adel", cyc), 32'(D_excAdEL), 32'(h.adel));
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 9))
            0: return $urandom;
            1: return 32'h3000 + $urandom_range(0, 3);
            2: return 32'h7000;
            default: return 32'h3000 + 4 * $urandom_range(0, 4095);
        endcase
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("por_valid", 32'(D_valid), 32'd0);
        chk("por_count", 32'(count), 32'd0);
        chk("por_fen", 32'(F_en), 32'd1);
        chk("por_pc", D_PC, 32'd0);
        #10 reset = 1'b0;

        // fv, pc, instr, dr | valid, pc, instr, adel, count, fen
        vecs[0] = '{1'b1, 32'h3000, 32'h3C01_1234, 1'b0, 1'b1, 32'h3000, 32'h3C01_1234, 1'b0, 1, 1'b1};
        vecs[1] = '{1'b1, 32'h3002, 32'h1111_1111, 1'b0, 1'b1, 32'h3000, 32'h3C01_1234, 1'b0, 2, 1'b1};
        vecs[2] = '{1'b0, 32'h0,    32'h0,         1'b1, 1'b1, 32'h3002, 32'h0,         1'b1, 1, 1'b1};
        vecs[3] = '{1'b1, 32'h7000, 32'h2222_2222, 1'b1, 1'b1, 32'h7000, 32'h0,         1'b1, 1, 1'b1};
        vecs[4] = '{1'b1, 32'h6FFC, 32'h3333_3333, 1'b1, 1'b1, 32'h6FFC, 32'h3333_3333, 1'b0, 1, 1'b1};
        vecs[5] = '{1'b1, 32'h2FFC, 32'h4444_4444, 1'b1, 1'b1, 32'h2FFC, 32'h0,         1'b1, 1, 1'b1};
        vecs[6] = '{1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0,    32'h0,         1'b0, 0, 1'b1};
        vecs[7] = '{1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0,    32'h0,         1'b0, 0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].dr, 1'b0);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(D_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_pc", i), D_PC, vecs[i].e_pc);
            chk($sformatf("vec%0d_instr", i), D_Instr, vecs[i].e_instr);
            chk($sformatf("vec%0d_adel", i), 32'(D_excAdEL), 32'(vecs[i].e_adel));
            chk($sformatf("vec%0d_count", i), 32'(count), vecs[i].e_count);
            chk($sformatf("vec%0d_fen", i), 32'(F_en), 32'(vecs[i].e_fen));
        end

        // Overfill: fifth fetch is dropped, then drain in order.
        async_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_fen", 32'(F_en), 32'd0);
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_pc", i), D_PC, 32'h3000 + 32'(4 * i));
            chk($sformatf("drain%0d_instr", i), D_Instr, 32'hA000_0000 + 32'(i));
            step();
        end
        chk("drained_valid", 32'(D_valid), 32'd0);

        // Full with simultaneous fetch and decode: only the dequeue lands.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h3000 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
            step();
        end
        set_in(1'b1, 32'h3010, 32'h0, 1'b1, 1'b0);
        chk("fr_fen_before", 32'(F_en), 32'd0);
        step();
        chk("fr_count", 32'(count), 32'd3);
        chk("fr_head", D_PC, 32'h3004);
        set_in(1'b1, 32'h3010, 32'h0, 1'b0, 1'b0);
        step();
        chk("fr_refill_count", 32'(count), 32'd4);
        chk("fr_refill_fen", 32'(F_en), 32'd0);
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fr_order%0d", i), D_PC, 32'h3004 + 32'(4 * i));
            step();
        end

        // Flush beats concurrent enqueue and dequeue.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h3100 + 32'(4 * i), 32'h5555_0000, 1'b0, 1'b0);
            step();
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        set_in(1'b1, 32'h3200, 32'h6666_0000, 1'b1, 1'b1);
        step();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(D_valid), 32'd0);
        chk("flush_instr", D_Instr, 32'd0);
        set_in(1'b1, 32'h3400, 32'h7777_0000, 1'b0, 1'b0);
        step();
        chk("post_flush_head", D_PC, 32'h3400);
        chk("post_flush_count", 32'(count), 32'd1);

        // Mid-operation reset, then pointer wrap with continuous traffic.
        set_in(1'b1, 32'h3404, 32'h0, 1'b0, 1'b0);
        step();
        chk("pre_rst_count", 32'(count), 32'd2);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'h3000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
            step();
            chk($sformatf("wrap%0d_pc", i), D_PC, 32'h3000 + 32'(4 * i));
            chk($sformatf("wrap%0d_instr", i), D_Instr, 32'hB000_0000 + 32'(i));
            chk($sformatf("wrap%0d_count", i), 32'(count), 32'd1);
        end

        // Randomized traffic against the reference queue.
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        async_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            set_in($urandom_range(0, 3) != 0, rand_pc(), $urandom,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
            model_edge();
            step();
            model_check(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
